// File: rtl/decode_stage.sv
// Decode stage of the ASIP pipeline: instruction decode, 16x32 register file,
// writeback destination chain and read-after-write stall generation.
module decode_stage #(
   parameter int WB_DEPTH = 3
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] INSTRUCTION,
   input  logic [31:0] WD3,
   input  logic        FLUSH,
   output logic        STALL,
   output logic        VALID,
   output logic [31:0] RD1,
   output logic [31:0] RD2,
   output logic [31:0] IMM,
   output logic [3:0]  RD_ADDR,
   output logic [1:0]  ALU_OP,
   output logic        ALU_SRC,
   output logic        REG_WRITE,
   output logic        MEM_WRITE,
   output logic        MEM_TO_REG,
   output logic        PC_SRC,
   output logic        ILLEGAL
);

   localparam int LAST = WB_DEPTH - 1;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_ADDI = 4'd5,
      OP_LDR  = 4'd6,
      OP_STR  = 4'd7,
      OP_B    = 4'd8
   } opcode_e;

   typedef struct packed {
      logic        valid;
      logic        illegal;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [3:0]  rdAddr;
      logic [1:0]  aluOp;
      logic        aluSrc;
      logic        regWrite;
      logic        memWrite;
      logic        memToReg;
      logic        pcSrc;
   } decOut_t;

   logic [3:0]  opcode;
   logic [3:0]  rd;
   logic [3:0]  rs1;
   logic [3:0]  rs2;
   logic [31:0] immExt;

   logic        decLegal;
   logic [1:0]  decAluOp;
   logic        decAluSrc;
   logic        decRegWrite;
   logic        decMemWrite;
   logic        decMemToReg;
   logic        decPcSrc;
   logic        usesRs1;
   logic        usesRs2;

   logic [31:0] operand1;
   logic [31:0] operand2;
   logic        hazard;

   decOut_t     outQ;
   decOut_t     outD;
   logic        wbEnQ   [WB_DEPTH];
   logic [3:0]  wbAddrQ [WB_DEPTH];
   logic [31:0] regsQ   [16];

   assign opcode = INSTRUCTION[31:28];
   assign rd     = INSTRUCTION[27:24];
   assign rs1    = INSTRUCTION[23:20];
   assign rs2    = INSTRUCTION[19:16];
   assign immExt = {{16{INSTRUCTION[15]}}, INSTRUCTION[15:0]};

   always_comb begin
      decLegal    = 1'b1;
      decAluOp    = 2'b00;
      decAluSrc   = 1'b0;
      decRegWrite = 1'b0;
      decMemWrite = 1'b0;
      decMemToReg = 1'b0;
      decPcSrc    = 1'b0;
      usesRs1     = 1'b0;
      usesRs2     = 1'b0;
      case (opcode)
         OP_NOP: ;
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            decAluOp    = 2'(opcode - 4'd1);
            decRegWrite = 1'b1;
            usesRs1     = 1'b1;
            usesRs2     = 1'b1;
         end
         OP_ADDI: begin
            decAluSrc   = 1'b1;
            decRegWrite = 1'b1;
            usesRs1     = 1'b1;
         end
         OP_LDR: begin
            decAluSrc   = 1'b1;
            decRegWrite = 1'b1;
            decMemToReg = 1'b1;
            usesRs1     = 1'b1;
         end
         OP_STR: begin
            decAluSrc   = 1'b1;
            decMemWrite = 1'b1;
            usesRs1     = 1'b1;
            usesRs2     = 1'b1;
         end
         OP_B: begin
            decAluSrc   = 1'b1;
            decPcSrc    = 1'b1;
            usesRs1     = 1'b1;
         end
         default: decLegal = 1'b0;
      endcase
   end

   // The last chain stage writes the file at this edge, so its data is bypassed.
   always_comb begin
      operand1 = regsQ[rs1];
      operand2 = regsQ[rs2];
      if (wbEnQ[LAST] && wbAddrQ[LAST] == rs1) operand1 = WD3;
      if (wbEnQ[LAST] && wbAddrQ[LAST] == rs2) operand2 = WD3;
      if (rs1 == 4'd0) operand1 = '0;
      if (rs2 == 4'd0) operand2 = '0;
   end

   always_comb begin
      hazard = 1'b0;
      for (int k = 0; k < LAST; k++) begin
         if (wbEnQ[k]) begin
            if (usesRs1 && rs1 != 4'd0 && wbAddrQ[k] == rs1) hazard = 1'b1;
            if (usesRs2 && rs2 != 4'd0 && wbAddrQ[k] == rs2) hazard = 1'b1;
         end
      end
   end

   assign STALL = hazard && !FLUSH;

   always_comb begin
      outD = '0;
      if (!(FLUSH || hazard)) begin
         if (decLegal) begin
            outD.valid    = 1'b1;
            outD.rd1      = operand1;
            outD.rd2      = operand2;
            outD.imm      = immExt;
            outD.rdAddr   = rd;
            outD.aluOp    = decAluOp;
            outD.aluSrc   = decAluSrc;
            outD.regWrite = decRegWrite;
            outD.memWrite = decMemWrite;
            outD.memToReg = decMemToReg;
            outD.pcSrc    = decPcSrc;
         end else begin
            outD.illegal  = 1'b1;
         end
      end
   end

   // The chain shifts unconditionally; a stalled or flushed slot enters as en=0.
   always_ff @(posedge CLK) begin
      if (RST) begin
         outQ <= '0;
         for (int k = 0; k < WB_DEPTH; k++) begin
            wbEnQ[k]   <= 1'b0;
            wbAddrQ[k] <= 4'd0;
         end
         for (int r = 0; r < 16; r++) regsQ[r] <= '0;
      end else begin
         outQ       <= outD;
         wbEnQ[0]   <= outD.regWrite && (outD.rdAddr != 4'd0);
         wbAddrQ[0] <= outD.rdAddr;
         for (int k = 1; k < WB_DEPTH; k++) begin
            wbEnQ[k]   <= wbEnQ[k-1];
            wbAddrQ[k] <= wbAddrQ[k-1];
         end
         if (wbEnQ[LAST] && wbAddrQ[LAST] != 4'd0) regsQ[wbAddrQ[LAST]] <= WD3;
      end
   end

   assign VALID      = outQ.valid;
   assign ILLEGAL    = outQ.illegal;
   assign RD1        = outQ.rd1;
   assign RD2        = outQ.rd2;
   assign IMM        = outQ.imm;
   assign RD_ADDR    = outQ.rdAddr;
   assign ALU_OP     = outQ.aluOp;
   assign ALU_SRC    = outQ.aluSrc;
   assign REG_WRITE  = outQ.regWrite;
   assign MEM_WRITE  = outQ.memWrite;
   assign MEM_TO_REG = outQ.memToReg;
   assign PC_SRC     = outQ.pcSrc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage with the default writeback depth of 3.
module tb_decode_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] instruction;
   logic [31:0] wd3;
   logic        flush;
   logic        stall;
   logic        valid;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic [31:0] imm;
   logic [3:0]  rdAddr;
   logic [1:0]  aluOp;
   logic        aluSrc;
   logic        regWrite;
   logic        memWrite;
   logic        memToReg;
   logic        pcSrc;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   decode_stage #(.WB_DEPTH(3)) dut (
      .CLK(clock), .RST(reset), .INSTRUCTION(instruction), .WD3(wd3), .FLUSH(flush),
      .STALL(stall), .VALID(valid), .RD1(rd1), .RD2(rd2), .IMM(imm), .RD_ADDR(rdAddr),
      .ALU_OP(aluOp), .ALU_SRC(aluSrc), .REG_WRITE(regWrite), .MEM_WRITE(memWrite),
      .MEM_TO_REG(memToReg), .PC_SRC(pcSrc), .ILLEGAL(illegal)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n, input logic [31:0] data);
      instruction = 32'h0000_0000;
      wd3 = data;
      for (int i = 0; i < n; i++) tick();
   endtask

   // OR r0,rs1,rs2 reads both sources without creating a chain entry.
   task automatic readPair(input logic [3:0] a, input logic [3:0] b,
                           output logic [31:0] v1, output logic [31:0] v2);
      instruction = {4'h4, 4'h0, a, b, 16'h0000};
      tick();
      v1 = rd1;
      v2 = rd2;
   endtask

   task automatic test_reset();
      logic [31:0] v1, v2;
      reset = 1'b1;
      flush = 1'b0;
      wd3 = 32'h0;
      instruction = 32'h1123_0000;
      tick();
      tick();
      checks++;
      if ({valid, illegal, rd1, rd2, imm, rdAddr, aluOp, aluSrc, regWrite, memWrite, memToReg, pcSrc} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got valid=%b ill=%b rd1=%h rd2=%h imm=%h rd=%h op=%b expected all 0",
                  valid, illegal, rd1, rd2, imm, rdAddr, aluOp);
      end
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_stall: got %b expected 0", stall);
      end
      reset = 1'b0;
      for (int r = 1; r < 16; r++) begin
         readPair(4'(r), 4'(r), v1, v2);
         checks++;
         if (v1 !== 32'h0 || v2 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_reg r%0d: got %h/%h expected 0", r, v1, v2);
         end
      end
   endtask

   task automatic test_addi();
      logic [31:0] v1, v2;
      instruction = 32'h510F_FFFF;
      tick();
      checks++;
      if ({valid, rdAddr, imm, aluSrc, regWrite, aluOp, memWrite, memToReg, pcSrc, illegal}
          !== {1'b1, 4'd1, 32'hFFFF_FFFF, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL addi_decode: got valid=%b rd=%h imm=%h src=%b rw=%b op=%b expected 1 1 ffffffff 1 1 00",
                  valid, rdAddr, imm, aluSrc, regWrite, aluOp);
      end
      idle(3, 32'h1234_5678);
      readPair(4'd1, 4'd1, v1, v2);
      checks++;
      if (v1 !== 32'h1234_5678) begin
         errors++;
         $display("[TB] FAIL addi_writeback: got %h expected 12345678", v1);
      end
   endtask

   task automatic test_opcodes();
      logic [31:0] instr [7];
      logic [6:0]  ctl   [7];
      logic [31:0] immX  [7];
      instr[0] = 32'h0000_0000; ctl[0] = 7'b00_0_0_0_0_0; immX[0] = 32'h0000_0000;
      instr[1] = 32'h2000_0001; ctl[1] = 7'b01_0_1_0_0_0; immX[1] = 32'h0000_0001;
      instr[2] = 32'h3000_0002; ctl[2] = 7'b10_0_1_0_0_0; immX[2] = 32'h0000_0002;
      instr[3] = 32'h4000_0003; ctl[3] = 7'b11_0_1_0_0_0; immX[3] = 32'h0000_0003;
      instr[4] = 32'h6000_8000; ctl[4] = 7'b00_1_1_0_1_0; immX[4] = 32'hFFFF_8000;
      instr[5] = 32'h7FF0_7FFF; ctl[5] = 7'b00_1_0_1_0_0; immX[5] = 32'h0000_7FFF;
      instr[6] = 32'h80F0_0010; ctl[6] = 7'b00_1_0_0_0_1; immX[6] = 32'h0000_0010;
      wd3 = 32'h0;
      for (int i = 0; i < 7; i++) begin
         instruction = instr[i];
         #1;
         checks++;
         if (stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL opcode%0d_stall: got %b expected 0", i, stall);
         end
         tick();
         checks++;
         if ({valid, aluOp, aluSrc, regWrite, memWrite, memToReg, pcSrc, imm} !== {1'b1, ctl[i], immX[i]}) begin
            errors++;
            $display("[TB] FAIL opcode%0d_decode: got v=%b ctl=%b imm=%h expected v=1 ctl=%b imm=%h",
                     i, valid, {aluOp, aluSrc, regWrite, memWrite, memToReg, pcSrc}, imm, ctl[i], immX[i]);
         end
      end
   endtask

   task automatic test_raw_hazard();
      logic [31:0] v1, v2;
      wd3 = 32'h0;
      instruction = 32'h5100_0005;
      tick();
      instruction = 32'h1211_0000;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("[TB] FAIL raw_stall1: got %b expected 1", stall);
      end
      tick();
      checks++;
      if (valid !== 1'b0 || stall !== 1'b1) begin
         errors++;
         $display("[TB] FAIL raw_stall2: got valid=%b stall=%b expected 0 1", valid, stall);
      end
      tick();
      checks++;
      if (valid !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL raw_release: got valid=%b stall=%b expected 0 0", valid, stall);
      end
      wd3 = 32'h0000_0005;
      tick();
      checks++;
      if ({valid, rdAddr, rd1, rd2} !== {1'b1, 4'd2, 32'd5, 32'd5}) begin
         errors++;
         $display("[TB] FAIL raw_bypass: got valid=%b rd=%h rd1=%h rd2=%h expected 1 2 5 5",
                  valid, rdAddr, rd1, rd2);
      end
      idle(3, 32'h0);
      readPair(4'd1, 4'd1, v1, v2);
      checks++;
      if (v1 !== 32'd5) begin
         errors++;
         $display("[TB] FAIL raw_regfile: got %h expected 5", v1);
      end
   endtask

   task automatic test_r0();
      logic [31:0] v1, v2;
      instruction = 32'h1012_0000;
      tick();
      instruction = 32'h1200_0000;
      wd3 = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL r0_no_stall: got %b expected 0", stall);
      end
      tick();
      checks++;
      if ({valid, rdAddr, rd1, rd2} !== {1'b1, 4'd2, 32'd0, 32'd0}) begin
         errors++;
         $display("[TB] FAIL r0_operands: got valid=%b rd=%h rd1=%h rd2=%h expected 1 2 0 0",
                  valid, rdAddr, rd1, rd2);
      end
      idle(4, 32'hDEAD_BEEF);
      wd3 = 32'h0;
      readPair(4'd0, 4'd1, v1, v2);
      checks++;
      if (v1 !== 32'h0 || v2 !== 32'd5) begin
         errors++;
         $display("[TB] FAIL r0_read: got r0=%h r1=%h expected 0 5", v1, v2);
      end
      readPair(4'd2, 4'd2, v1, v2);
      checks++;
      if (v1 !== 32'hDEAD_BEEF) begin
         errors++;
         $display("[TB] FAIL r2_write: got %h expected deadbeef", v1);
      end
   endtask

   task automatic test_flush();
      logic [31:0] v1, v2;
      wd3 = 32'h0;
      instruction = 32'h5300_0007;
      tick();
      instruction = 32'h1430_0000;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_pre_stall: got %b expected 1", stall);
      end
      flush = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_stall: got %b expected 0", stall);
      end
      tick();
      checks++;
      if (valid !== 1'b0 || regWrite !== 1'b0 || illegal !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_bubble: got valid=%b rw=%b ill=%b expected 0 0 0", valid, regWrite, illegal);
      end
      flush = 1'b0;
      instruction = 32'h0;
      tick();
      wd3 = 32'h0000_0007;
      tick();
      wd3 = 32'h0;
      readPair(4'd3, 4'd4, v1, v2);
      checks++;
      if (v1 !== 32'd7 || v2 !== 32'd0) begin
         errors++;
         $display("[TB] FAIL flush_writeback: got r3=%h r4=%h expected 7 0", v1, v2);
      end
   endtask

   task automatic test_illegal();
      instruction = 32'hF000_0000;
      tick();
      checks++;
      if ({illegal, valid, regWrite} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL illegal_f: got ill=%b valid=%b rw=%b expected 1 0 0", illegal, valid, regWrite);
      end
      instruction = 32'h9500_0000;
      tick();
      checks++;
      if ({illegal, valid, regWrite} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL illegal_9: got ill=%b valid=%b rw=%b expected 1 0 0", illegal, valid, regWrite);
      end
      instruction = 32'h1655_0000;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL illegal_no_chain: got stall=%b expected 0", stall);
      end
      tick();
      checks++;
      if ({illegal, valid} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL illegal_clear: got ill=%b valid=%b expected 0 1", illegal, valid);
      end
      idle(3, 32'h0);
   endtask

   task automatic test_reset_midflight();
      logic [31:0] v1, v2;
      instruction = 32'h5600_0009;
      tick();
      reset = 1'b1;
      instruction = 32'h0;
      tick();
      reset = 1'b0;
      idle(3, 32'h0000_AAAA);
      wd3 = 32'h0;
      readPair(4'd6, 4'd1, v1, v2);
      checks++;
      if (v1 !== 32'h0 || v2 !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_midflight: got r6=%h r1=%h expected 0 0", v1, v2);
      end
   endtask

   initial begin
      $display("[TB] decode_stage directed tests starting");
      test_reset();
      test_addi();
      test_opcodes();
      test_raw_hazard();
      test_r0();
      test_flush();
      test_illegal();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
